test_select_encoder: RTL and testbench



---
 rtl/test_select_encoder.sv | 219 +++++++++++++++++++++
 tb/tb_test_select_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_select_encoder.sv
// test_select_encoder: turns the raw test and select push-buttons into the
// test-mode level and the selected scenario code that the central pet FSM
// consumes. Long press enters test mode, select taps pick 1..MAX_SEL,
// another long press leaves. The code is held for HOLD_MS after test_mode
// drops so the FSM can latch it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | test mode off, waiting for a long test press
// ACTIVE   | test mode on, select taps step the code
// HOLD     | test mode off, code frozen for HOLD_MS ticks
// WAIT_REL | code cleared, waiting for test release before re-arming entry

module test_select_encoder #(
    parameter int TICK_DIV    = 50000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 2000,
    parameter int HOLD_MS     = 100,
    parameter int MAX_SEL     = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_test_n,
    input  logic       btn_sel_n,
    output logic       test_mode,
    output logic [3:0] test_count,
    output logic       sel_pulse,
    output logic       test_exit
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int LW = $clog2(LONG_MS + 1);
    localparam int HW = $clog2(HOLD_MS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MS - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_MS);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_MS);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [3:0]    MAX_CODE  = 4'(MAX_SEL);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    // bit 0 = test button, bit 1 = select button throughout
    logic [1:0]         test_sync_q, sel_sync_q;
    logic [1:0]         sync_pressed;
    logic [TW-1:0]      tick_cnt_q;
    logic               tick;
    logic [1:0]         db_q, db_prev_q;
    logic [1:0][DW-1:0] db_cnt_q;
    logic [1:0]         rise;
    logic               test_fall;
    logic [LW-1:0]      press_tmr_q;
    logic               long_evt;
    logic               short_rel;

    logic [1:0]    state_q, state_d;
    logic          mode_q, mode_d;
    logic [3:0]    count_q, count_d;
    logic          armed_q, armed_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          sel_q, sel_d;
    logic          exit_q, exit_d;

    // Two-flop synchronizers; reset to the released (high) raw level
    always_ff @(posedge clk) begin
        if (rst) begin
            test_sync_q <= 2'b11;
            sel_sync_q  <= 2'b11;
        end else begin
            test_sync_q <= {test_sync_q[0], btn_test_n};
            sel_sync_q  <= {sel_sync_q[0], btn_sel_n};
        end
    end

    assign sync_pressed = {~sel_sync_q[1], ~test_sync_q[1]};

    // Free-running 1 ms tick divider
    always_ff @(posedge clk) begin
        if (rst)
            tick_cnt_q <= '0;
        else if (tick)
            tick_cnt_q <= '0;
        else
            tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    assign tick = (tick_cnt_q == TICK_LAST);

    // Per-button debounce: level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_MS consecutive ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
        end else begin
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (tick) begin
                    if (sync_pressed[i] == db_q[i]) begin
                        db_cnt_q[i] <= '0;
                    end else if (db_cnt_q[i] == DB_LAST) begin
                        db_q[i]     <= sync_pressed[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign rise      = db_q & ~db_prev_q;
    assign test_fall = ~db_q[0] & db_prev_q[0];

    // Press-duration timer for the test button, saturating so long fires once
    always_ff @(posedge clk) begin
        if (rst || !db_q[0])
            press_tmr_q <= '0;
        else if (tick && press_tmr_q != LONG_SAT)
            press_tmr_q <= press_tmr_q + 1'b1;
    end

    assign long_evt = tick && db_q[0] && (press_tmr_q == LONG_LAST);
    // The timer still holds the press length on the cycle the release is seen
    assign short_rel = test_fall && (press_tmr_q != LONG_SAT);

    // Sequencer next-state and output decode
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        armed_d = armed_q;
        hold_d  = hold_q;
        sel_d   = 1'b0;
        exit_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (long_evt) begin
                    mode_d  = 1'b1;
                    count_d = 4'd0;
                    armed_d = 1'b0;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Exit wins over a coincident select so the chosen code is not disturbed
                if (long_evt && armed_q && count_q != 4'd0) begin
                    mode_d  = 1'b0;
                    exit_d  = 1'b1;
                    armed_d = 1'b0;
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    if (rise[1]) begin
                        count_d = (count_q >= MAX_CODE) ? 4'd1 : count_q + 4'd1;
                        sel_d   = 1'b1;
                    end
                    // The press that entered test mode is still down; only a fresh press arms
                    if (rise[0])
                        armed_d = 1'b1;
                    if (test_fall) begin
                        armed_d = 1'b0;
                        if (armed_q && short_rel)
                            count_d = 4'd0;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (hold_q <= HOLD_ONE) begin
                        count_d = 4'd0;
                        state_d = ST_WAIT_REL;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            ST_WAIT_REL: begin
                if (!db_q[0])
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            count_q <= 4'd0;
            armed_q <= 1'b0;
            hold_q  <= '0;
            sel_q   <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            armed_q <= armed_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            exit_q  <= exit_d;
        end
    end

    assign test_mode  = mode_q;
    assign test_count = count_q;
    assign sel_pulse  = sel_q;
    assign test_exit  = exit_q;

endmodule

// File: tb/tb_test_select_encoder.sv
// Bench for test_select_encoder: user-level actions (select tap, short or long
// test press) checked against a button-level model of the test interface.
module tb_test_select_encoder;

    localparam int TICK_DIV    = 4;
    localparam int DEBOUNCE_MS = 3;
    localparam int LONG_MS     = 10;
    localparam int HOLD_MS     = 5;
    localparam int MAX_SEL     = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_test_n = 1'b1;
    logic       btn_sel_n = 1'b1;
    logic       test_mode;
    logic [3:0] test_count;
    logic       sel_pulse;
    logic       test_exit;

    test_select_encoder #(
        .TICK_DIV(TICK_DIV), .DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS),
        .HOLD_MS(HOLD_MS), .MAX_SEL(MAX_SEL)
    ) dut (
        .clk(clk), .rst(rst), .btn_test_n(btn_test_n), .btn_sel_n(btn_sel_n),
        .test_mode(test_mode), .test_count(test_count),
        .sel_pulse(sel_pulse), .test_exit(test_exit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Event counters, sampled mid-cycle
    int   mon_sel = 0;
    int   mon_exit = 0;
    int   mon_rise = 0;
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        if (sel_pulse === 1'b1) mon_sel++;
        if (test_exit === 1'b1) mon_exit++;
        if (test_mode === 1'b1 && mon_prev !== 1'b1) mon_rise++;
        mon_prev = test_mode;
    end

    // User-level model: is test mode on, and which code is selected
    bit m_mode = 1'b0;
    int m_count = 0;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic act_sel(input string nm, input int hold_clk, input bit bounce);
        int s_sel;
        int exp_p;
        logic [3:0] exp_c;
        s_sel = mon_sel;
        if (bounce)
            for (int i = 0; i < 20; i++) begin
                btn_sel_n = ~btn_sel_n;
                wait_clk(2);
            end
        btn_sel_n = 1'b0;
        wait_clk(hold_clk);
        btn_sel_n = 1'b1;
        wait_clk(40);
        if (m_mode) begin
            m_count = (m_count == MAX_SEL) ? 1 : m_count + 1;
            exp_p = 1;
        end else begin
            exp_p = 0;
        end
        exp_c = m_count[3:0];
        n_cmp++;
        if (mon_sel - s_sel != exp_p) begin
            n_fail++;
            $display("FAIL %s sel_pulses: got %0d want %0d", nm, mon_sel - s_sel, exp_p);
        end
        n_cmp++;
        if (test_count !== exp_c) begin
            n_fail++;
            $display("FAIL %s test_count: got %0d want %0d", nm, test_count, exp_c);
        end
        n_cmp++;
        if (test_mode !== m_mode) begin
            n_fail++;
            $display("FAIL %s test_mode: got %b want %b", nm, test_mode, m_mode);
        end
    endtask

    task automatic act_test(input string nm, input int hold_clk, input bit long_p);
        bit exp_enter, exp_exit, frozen_bad;
        logic [3:0] code, exp_c;
        int s_sel, s_exit, s_rise, exit_i, zero_i, rise_i;
        exp_enter = long_p && !m_mode;
        exp_exit  = long_p && m_mode && (m_count != 0);
        code = m_count[3:0];
        s_sel = mon_sel; s_exit = mon_exit; s_rise = mon_rise;
        exit_i = -1; zero_i = -1; rise_i = -1; frozen_bad = 1'b0;
        btn_test_n = 1'b0;
        for (int i = 0; i < hold_clk; i++) begin
            wait_clk(1);
            if (rise_i < 0 && !m_mode && test_mode === 1'b1) rise_i = i + 1;
            if (exit_i < 0 && test_exit === 1'b1) begin
                exit_i = i + 1;
            end else if (exit_i >= 0 && zero_i < 0) begin
                if (test_count === 4'd0) zero_i = i + 1;
                else if (test_count !== code || test_mode !== 1'b0) frozen_bad = 1'b1;
            end
        end
        btn_test_n = 1'b1;
        wait_clk(40);
        if (exp_enter) begin m_mode = 1'b1; m_count = 0; end
        else if (exp_exit) begin m_mode = 1'b0; m_count = 0; end
        else if (!long_p && m_mode) m_count = 0;
        exp_c = m_count[3:0];
        n_cmp++;
        if (test_mode !== m_mode) begin
            n_fail++;
            $display("FAIL %s test_mode: got %b want %b", nm, test_mode, m_mode);
        end
        n_cmp++;
        if (test_count !== exp_c) begin
            n_fail++;
            $display("FAIL %s test_count: got %0d want %0d", nm, test_count, exp_c);
        end
        n_cmp++;
        if (mon_rise - s_rise != int'(exp_enter)) begin
            n_fail++;
            $display("FAIL %s mode_rises: got %0d want %0d", nm, mon_rise - s_rise, exp_enter);
        end
        n_cmp++;
        if (mon_exit - s_exit != int'(exp_exit)) begin
            n_fail++;
            $display("FAIL %s exit_pulses: got %0d want %0d", nm, mon_exit - s_exit, exp_exit);
        end
        n_cmp++;
        if (mon_sel != s_sel) begin
            n_fail++;
            $display("FAIL %s sel_pulses: got %0d want 0", nm, mon_sel - s_sel);
        end
        if (exp_enter) begin
            // 2 sync clk + 3..4 debounce ticks + 10 press ticks + 1 register
            n_cmp++;
            if (rise_i < 44 || rise_i > 60) begin
                n_fail++;
                $display("FAIL %s entry_latency: got %0d clk want 44..60", nm, rise_i);
            end
        end
        if (exp_exit) begin
            n_cmp++;
            if (zero_i < 0 || zero_i - exit_i < 16 || zero_i - exit_i > 22) begin
                n_fail++;
                $display("FAIL %s hold_len: got %0d clk want 16..22", nm, zero_i - exit_i);
            end
            n_cmp++;
            if (frozen_bad) begin
                n_fail++;
                $display("FAIL %s hold_frozen: got changed want code %0d mode 0", nm, code);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        n_cmp++;
        if ({test_mode, test_count, sel_pulse, test_exit} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b%h%b%b want 0", test_mode, test_count, sel_pulse, test_exit);
        end
        rst = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_entry();
        act_sel("idle_tap", 30, 1'b0);
        act_test("idle_short", 32, 1'b0);
        act_test("entry", 100, 1'b1);
    endtask

    task automatic test_bounce();
        act_sel("bounce", 30, 1'b1);
    endtask

    task automatic test_select_exit();
        act_test("clear_short", 28, 1'b0);
        for (int i = 0; i < 3; i++) act_sel("tap3", 28, 1'b0);
        act_test("exit3", 100, 1'b1);
    endtask

    task automatic test_wrap_cancel();
        act_test("enter_wrap", 100, 1'b1);
        for (int i = 0; i < 11; i++) act_sel("wrap", 26, 1'b0);
        n_cmp++;
        if (test_count !== 4'd2) begin
            n_fail++;
            $display("FAIL wrap_11 test_count: got %0d want 2", test_count);
        end
        act_test("cancel_short", 30, 1'b0);
        act_test("long_at_zero", 100, 1'b1);
    endtask

    task automatic test_hold_through();
        act_sel("ht_tap", 30, 1'b0);
        act_test("hold_through", 200, 1'b1);
        act_test("reenter", 100, 1'b1);
    endtask

    task automatic test_reset_mid();
        int s_exit;
        while (m_count != 5) act_sel("to5", 28, 1'b0);
        n_cmp++;
        if (test_count !== 4'd5 || test_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst state: got mode %b count %0d want 1 5", test_mode, test_count);
        end
        s_exit = mon_exit;
        rst = 1'b1;
        wait_clk(1);
        n_cmp++;
        if (test_mode !== 1'b0 || test_count !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_rst outputs: got mode %b count %0d want 0 0", test_mode, test_count);
        end
        rst = 1'b0;
        wait_clk(2);
        n_cmp++;
        if (mon_exit != s_exit) begin
            n_fail++;
            $display("FAIL mid_rst exit_pulses: got %0d want 0", mon_exit - s_exit);
        end
        m_mode = 1'b0;
        m_count = 0;
        act_test("after_rst", 100, 1'b1);
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      act_sel("rnd_sel", int'($urandom_range(24, 40)), 1'b0);
            else if (r < 65) act_test("rnd_short", int'($urandom_range(20, 32)), 1'b0);
            else             act_test("rnd_long", int'($urandom_range(90, 110)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_bounce();
        test_select_exit();
        test_wrap_cancel();
        test_hold_through();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
